// File: rtl/mem_port_arbiter.sv
// Round-robin N-to-1 arbiter from CPU-side memory ports onto one physical port.
// One transaction in flight; requests are latched on grant and served to completion.
module mem_port_arbiter #(
    parameter  int NUM_PORTS  = 2,
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    localparam int BE_WIDTH   = DATA_WIDTH / 8,
    localparam int GW         = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            cmem_read,
    input  logic [NUM_PORTS-1:0]            cmem_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] cmem_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] cmem_wdata,
    input  logic [NUM_PORTS*BE_WIDTH-1:0]   cmem_byte_enable,
    output logic [NUM_PORTS-1:0]            cmem_resp,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] cmem_rdata,
    output logic                            pmem_read,
    output logic                            pmem_write,
    output logic [ADDR_WIDTH-1:0]           pmem_address,
    output logic [DATA_WIDTH-1:0]           pmem_wdata,
    output logic [BE_WIDTH-1:0]             pmem_byte_enable,
    input  logic                            pmem_resp,
    input  logic [DATA_WIDTH-1:0]           pmem_rdata,
    output logic                            busy,
    output logic [GW-1:0]                   grant_id
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [GW-1:0]         r_last_grant;
    logic [GW-1:0]         r_grant_id;
    logic                  r_op_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [BE_WIDTH-1:0]   r_be;
    logic [DATA_WIDTH-1:0] r_rdata [NUM_PORTS];

    logic                  w_found;
    logic [GW-1:0]         w_sel;
    int                    w_idx;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [BE_WIDTH-1:0]   w_sel_be;
    logic                  w_sel_wr;
    logic [NUM_PORTS-1:0]  w_resp;

    // Scan starts one past the last winner so every port gets a turn.
    always_comb begin
        w_found     = 1'b0;
        w_sel       = '0;
        w_idx       = 0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_be    = '0;
        w_sel_wr    = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            w_idx = (int'(r_last_grant) + i) % NUM_PORTS;
            if (!w_found && (cmem_read[w_idx] || cmem_write[w_idx])) begin
                w_found     = 1'b1;
                w_sel       = GW'(w_idx);
                w_sel_addr  = cmem_address[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = cmem_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH];
                w_sel_be    = cmem_byte_enable[w_idx*BE_WIDTH +: BE_WIDTH];
                w_sel_wr    = cmem_write[w_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_found) w_next = ST_ISSUE;
            ST_ISSUE: if (pmem_resp) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GW'(NUM_PORTS - 1);
            r_grant_id   <= '0;
            r_op_wr      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            for (int i = 0; i < NUM_PORTS; i++) r_rdata[i] <= '0;
        end else begin
            if (r_state == ST_IDLE && w_found) begin
                r_last_grant <= w_sel;
                r_grant_id   <= w_sel;
                r_op_wr      <= w_sel_wr;
                r_addr       <= w_sel_addr;
                r_wdata      <= w_sel_wdata;
                r_be         <= w_sel_be;
            end
            if (r_state == ST_ISSUE && pmem_resp && !r_op_wr)
                r_rdata[r_grant_id] <= pmem_rdata;
        end
    end

    // Strobes and response are decoded from state so reset kills them at once.
    always_comb begin
        w_resp = '0;
        if (r_state == ST_DONE) w_resp[r_grant_id] = 1'b1;
    end

    assign cmem_resp        = w_resp;
    assign pmem_read        = (r_state == ST_ISSUE) && !r_op_wr;
    assign pmem_write       = (r_state == ST_ISSUE) && r_op_wr;
    assign pmem_address     = r_addr;
    assign pmem_wdata       = r_wdata;
    assign pmem_byte_enable = r_be;
    assign busy             = (r_state != ST_IDLE);
    assign grant_id         = r_grant_id;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rdata
        assign cmem_rdata[g*DATA_WIDTH +: DATA_WIDTH] = r_rdata[g];
    end

endmodule
